// File: rtl/pe_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_sched_pkg : shared constants, state encoding and width helper for       |
// |                pe_mult_scheduler.  Revision 1.0                            |
// +----------------------------------------------------------------------------+
package pe_sched_pkg;

  localparam int LANES       = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_REQ = 3;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A single requester still needs a 1-bit id field.
  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : one-hot grant to the first requester at or after ptr,         |
// |              wrapping from NUM_REQ-1 to 0.  Revision 1.0                   |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_mult_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_mult_scheduler : round-robin burst scheduler feeding one registered     |
// |   4-lane multiplier; PE_SCHED_SATURATE_EN saturates lane products.  Rev 1.0|
// +----------------------------------------------------------------------------+
module pe_mult_scheduler
  import pe_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int ID_W   = calc_id_w(NUM_REQ),
  localparam int LW     = LANES * DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*LW-1:0]     req_ifm,
  input  logic [NUM_REQ*LW-1:0]     req_wgt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LW-1:0]             out_ofm,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last
);

  state_e              state, state_next;
  logic [ID_W-1:0]     ptr, ptr_next;
  logic [ID_W-1:0]     hold_id, hold_next;
  logic [NUM_REQ-1:0]  arb_grant, grant_vec;
  logic [ID_W-1:0]     arb_id, sel_id;
  logic                can_accept, accept, sel_last;
  logic [LW-1:0]       ifm_sel, wgt_sel, ofm_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  always_comb begin
    arb_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_grant[i]) arb_id = ID_W'(i);
  end

  // A stalled output register blocks every requester; reset blocks everything.
  assign can_accept = (!out_valid || out_ready) && !reset;
  assign sel_id     = (state == HOLD) ? hold_id : arb_id;
  assign grant_vec  = (state == HOLD) ? (NUM_REQ'(1) << hold_id) : arb_grant;
  assign req_ready  = grant_vec & {NUM_REQ{can_accept}};
  assign accept     = |(req_valid & req_ready);
  assign sel_last   = req_last[sel_id];
  assign ifm_sel    = req_ifm[int'(sel_id)*LW +: LW];
  assign wgt_sel    = req_wgt[int'(sel_id)*LW +: LW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef PE_SCHED_SATURATE_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, ifm_sel[l*DATA_W +: DATA_W]} *
                  {{DATA_W{1'b0}}, wgt_sel[l*DATA_W +: DATA_W]};
    assign ofm_next[l*DATA_W +: DATA_W] = (|prod[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                                        : prod[DATA_W-1:0];
`else
    assign ofm_next[l*DATA_W +: DATA_W] = ifm_sel[l*DATA_W +: DATA_W] *
                                          wgt_sel[l*DATA_W +: DATA_W];
`endif
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    hold_next  = hold_id;
    if (accept) begin
      if (sel_last) begin
        state_next = ARB;
        ptr_next   = (sel_id == ID_W'(NUM_REQ-1)) ? '0 : sel_id + 1'b1;
      end else begin
        state_next = HOLD;
        hold_next  = sel_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      ptr       <= '0;
      hold_id   <= '0;
      out_valid <= 1'b0;
      out_ofm   <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      hold_id <= hold_next;
      if (accept) begin
        out_valid <= 1'b1;
        out_ofm   <= ofm_next;
        out_id    <= sel_id;
        out_last  <= sel_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_mult_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pe_mult_scheduler : directed vector table plus burst/stall/reset        |
// |   sequences for pe_mult_scheduler.  Revision 1.0                           |
// +----------------------------------------------------------------------------+
module tb_pe_mult_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_ready, req_last;
  logic [95:0] req_ifm, req_wgt;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_ofm;
  logic [1:0]  out_id;

  int n_vec = 0;
  int n_err = 0;

  pe_mult_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_last  (req_last),
    .req_ifm   (req_ifm),
    .req_wgt   (req_wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ofm   (out_ofm),
    .out_id    (out_id),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] ifm;
    logic [31:0] wgt;
    logic [31:0] exp_trunc;
    logic [31:0] exp_sat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_ifm   = '0;
    req_wgt   = '0;
  endtask

  task automatic put(input int id, input logic [31:0] i, input logic [31:0] w);
    req_ifm[id*32 +: 32] = i;
    req_wgt[id*32 +: 32] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    vecs[0] = '{1, 32'h04030201, 32'h02020202, 32'h08060402, 32'h08060402};
    vecs[1] = '{0, 32'h0A0F10C8, 32'h0B111002, 32'h6EFF0090, 32'h6EFFFFFF};
    vecs[2] = '{2, 32'hFFFF0001, 32'hFF01FF01, 32'h01FF0001, 32'hFFFF0001};
    vecs[3] = '{1, 32'h80402007, 32'h02040809, 32'h0000003F, 32'hFFFFFF3F};
    vecs[4] = '{0, 32'h0C0B0A09, 32'h0C0B0A09, 32'h90796451, 32'h90796451};

    // Reset state, with all requesters valid during reset
    reset = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    req_valid = 3'b111;
    req_last  = 3'b111;
    #1;
    chk("reset_ready", 64'(req_ready), 64'h0);
    tick();
    chk("reset_ready_b", 64'(req_ready), 64'h0);
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_ofm", 64'(out_ofm), 64'h0);
    chk("reset_id", 64'(out_id), 64'h0);
    chk("reset_last", 64'(out_last), 64'h0);
    reset = 1'b0;
    idle_inputs();
    tick();

    // Single-beat vector table
    for (int v = 0; v < 5; v++) begin
      idle_inputs();
      put(vecs[v].id, vecs[v].ifm, vecs[v].wgt);
      req_valid[vecs[v].id] = 1'b1;
      req_last[vecs[v].id]  = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(3'b001 << vecs[v].id));
      tick();
      idle_inputs();
`ifdef PE_SCHED_SATURATE_EN
      exp = vecs[v].exp_sat;
`else
      exp = vecs[v].exp_trunc;
`endif
      chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'h1);
      chk($sformatf("v%0d_ofm", v), 64'(out_ofm), 64'(exp));
      chk($sformatf("v%0d_id", v), 64'(out_id), 64'(vecs[v].id));
      chk($sformatf("v%0d_last", v), 64'(out_last), 64'h1);
      tick();
      chk($sformatf("v%0d_drain", v), 64'(out_valid), 64'h0);
    end

    // Round-robin: all three valid, single-beat
    do_reset();
    req_valid = 3'b111;
    req_last  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr%0d_valid", k), 64'(out_valid), 64'h1);
      chk($sformatf("rr%0d_id", k), 64'(out_id), 64'(k % 3));
    end
    idle_inputs();
    tick();

    // Burst from 0 with a gap while 2 waits
    do_reset();
    req_valid = 3'b101;
    req_last  = 3'b100;
    #1;
    chk("burst_a_ready", 64'(req_ready), 64'h1);
    tick();
    chk("burst_a_id", 64'({out_valid, out_id, out_last}), 64'({1'b1, 2'd0, 1'b0}));
    req_valid = 3'b100;
    #1;
    chk("burst_gap_ready2", 64'(req_ready[2]), 64'h0);
    tick();
    chk("burst_gap_valid", 64'(out_valid), 64'h0);
    req_valid = 3'b101;
    tick();
    chk("burst_c_id", 64'({out_valid, out_id, out_last}), 64'({1'b1, 2'd0, 1'b0}));
    req_last = 3'b101;
    tick();
    chk("burst_d_id", 64'({out_valid, out_id, out_last}), 64'({1'b1, 2'd0, 1'b1}));
    req_valid = 3'b100;
    tick();
    chk("burst_e_id", 64'({out_valid, out_id, out_last}), 64'({1'b1, 2'd2, 1'b1}));
    idle_inputs();
    tick();

    // Output stall: req1 result held, req0 waits, then back-to-back release
    do_reset();
    out_ready = 1'b0;
    put(1, 32'h04030201, 32'h03030303);
    req_valid = 3'b010;
    req_last  = 3'b011;
    tick();
    put(0, 32'h05050505, 32'h05050505);
    req_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_out", k), {out_valid, out_id, out_last, out_ofm, 28'h0},
          {1'b1, 2'd1, 1'b1, 32'h0C090603, 28'h0});
      chk($sformatf("stall%0d_ready", k), 64'(req_ready), 64'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 3'b000;
    chk("release_out", {out_valid, out_id, out_last, out_ofm, 28'h0},
        {1'b1, 2'd0, 1'b1, 32'h19191919, 28'h0});
    tick();
    chk("release_empty", 64'(out_valid), 64'h0);

    // Reset during beat 2 of a burst from requester 1
    do_reset();
    req_valid = 3'b010;
    req_last  = 3'b000;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    req_valid = 3'b000;
    chk("midrst_valid", 64'(out_valid), 64'h0);
    tick();
    tick();
    chk("midrst_quiet", 64'(out_valid), 64'h0);
    req_valid = 3'b011;
    req_last  = 3'b011;
    #1;
    chk("midrst_grant", 64'(req_ready), 64'h1);
    tick();
    chk("midrst_id", 64'({out_valid, out_id}), 64'({1'b1, 2'd0}));
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_mult_scheduler.md
PE_MULT_SCHEDULER -- requirements
Module: pe_mult_scheduler

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 3, the number of requesters sharing one 4-lane multiplier.
REQ-002 The block SHALL take parameter DATA_W, default 8, the width of each IFM, weight and OFM lane.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-006 req_ready  out  NUM_REQ  per-requester beat accepted when valid and ready are both high.
REQ-007 req_last  in  NUM_REQ  marks the final beat of a requester's burst.
REQ-008 req_ifm  in  NUM_REQ*4*DATA_W  four IFM lanes per requester, lane 0 in the LSBs.
REQ-009 req_wgt  in  NUM_REQ*4*DATA_W  four weight lanes per requester, same packing.
REQ-010 out_valid  out  1  result beat valid.
REQ-011 out_ready  in  1  downstream accepts a result beat.
REQ-012 out_ofm  out  4*DATA_W  four lane products.
REQ-013 out_id  out  ID_W  index of the source requester.
REQ-014 out_last  out  1  copy of the accepted beat's req_last.

Function
REQ-015 The block SHALL implement states ARB and HOLD.
REQ-016 In ARB, the block SHALL grant the lowest index at or after the round-robin pointer whose req_valid is high, with wrap-around from NUM_REQ-1 to 0.
REQ-017 At most one req_ready bit SHALL be high in any cycle.
REQ-018 req_ready SHALL be high only for the granted requester, and only while the output stage is empty or being drained that cycle (out_ready=1).
REQ-019 On an accepted beat with req_last=0, the block SHALL enter HOLD and keep the grant on that requester until its beat with req_last=1 is accepted.
REQ-020 On an accepted beat with req_last=1, the block SHALL return to ARB and set the pointer to granted index +1, modulo NUM_REQ.
REQ-021 In HOLD, valid from other requesters SHALL be ignored.
REQ-022 In HOLD, a gap in the holder's req_valid SHALL keep the HOLD state and the grant.
REQ-023 Lane product i SHALL be the low DATA_W bits of ifm[i]*wgt[i], unsigned, unless REQ-032 applies.
REQ-024 The result SHALL be registered: out_valid rises exactly 1 cycle after the accepting handshake, with out_ofm/out_id/out_last.
REQ-025 While out_valid=1 and out_ready=0, all output fields SHALL hold stable and no new beat SHALL be accepted.
REQ-026 An accept and a drain in the same cycle SHALL give back-to-back output beats; sustained throughput SHALL be 1 beat per cycle.
REQ-027 When no requester is valid in ARB, the pointer SHALL not change.

Reset
REQ-028 With reset=1 at a clock edge: state=ARB, pointer=0, out_valid=0, out_ofm=0, out_id=0, out_last=0, and req_ready=0 in that cycle.
REQ-029 Reset asserted mid-burst or with a stalled output SHALL discard the burst and the pending result, with no beat emitted afterwards.

Configuration
REQ-030 Macro PE_SCHED_SATURATE_EN SHALL select the lane product overflow behaviour.
REQ-031 Without PE_SCHED_SATURATE_EN, lane products SHALL truncate per REQ-023.
REQ-032 With PE_SCHED_SATURATE_EN, a lane product exceeding 2^DATA_W-1 SHALL output 2^DATA_W-1.
REQ-033 The port list SHALL be identical with and without PE_SCHED_SATURATE_EN.

Structure
REQ-034 Package pe_sched_pkg SHALL hold LANES=4, default DATA_W and NUM_REQ, ID_W=$clog2(NUM_REQ), and the state enum {ARB, HOLD}.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arbiter with inputs request vector and pointer, and output one-hot grant.
REQ-036 Lane multiply and saturation SHALL be inline in pe_mult_scheduler.

Verification
REQ-037 Reset, then requester 1 sends ifm={4,3,2,1}, wgt={2,2,2,2}, last=1 -> the next cycle gives out_ofm={8,6,4,2}, out_id=1, out_last=1.
REQ-038 All three requesters hold valid with last=1 every beat for 6 cycles -> out_id sequence 0,1,2,0,1,2.
REQ-039 Requester 0 sends a 3-beat burst while requester 2 is valid, with one idle cycle after beat 1 -> out_id=0,0,0 then 2.
REQ-040 out_ready=0 for 4 cycles with a result pending -> outputs stable, req_ready all 0; after release, no beat is lost or duplicated.
REQ-041 ifm=200, wgt=2 -> out lane = 144 without PE_SCHED_SATURATE_EN, 255 with it.
REQ-042 Reset asserted during beat 2 of a burst -> out_valid=0, state ARB, pointer 0, and requester 0 granted first afterwards.
